// File: rtl/ssd_pkg.sv
// ssd_pkg: seven-segment glyph constants and sizing helpers for the scan controller
package ssd_pkg;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

  function automatic int digit_idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ssd_hex_decode.sv
// ssd_hex_decode: nibble to true-polarity seven-segment glyph
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);
  assign o_seg = hex_to_seg(i_nibble);
endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: multiplexed hex display scanner with tear-free loading, blanking, dp and blink
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 200000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [4*NUM_DIGITS-1:0] i_data_in,
  input  logic                    i_data_we,
  input  logic                    i_enable,
  input  logic                    i_blank_lz,
  input  logic [NUM_DIGITS-1:0]   i_dp_mask,
  input  logic [NUM_DIGITS-1:0]   i_blink_mask,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame_done,
  output logic                    o_load_pending
);
  localparam int IW = digit_idx_w(NUM_DIGITS);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int DL = 4 * NUM_DIGITS;

  logic [DW-1:0]         r_div_cnt;
  logic [IW-1:0]         r_digit_idx;
  logic [DL-1:0]         r_shadow, r_active;
  logic [BW-1:0]         r_blink_cnt;
  logic                  r_blink_phase, r_load_pending, r_frame_done;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;

  logic                  w_tick, w_wrap, w_blank, w_blink_wrap;
  logic [DW-1:0]         w_div_nxt;
  logic [IW-1:0]         w_idx_nxt;
  logic [NUM_DIGITS-1:0] w_lz, w_onehot;
  logic [3:0]            w_nibble;
  logic [6:0]            w_glyph;

  assign w_tick       = r_div_cnt == DW'(CLK_DIV - 1);
  assign w_wrap       = w_tick && r_digit_idx == IW'(NUM_DIGITS - 1);
  assign w_div_nxt    = w_tick ? '0 : r_div_cnt + DW'(1);
  assign w_idx_nxt    = w_wrap ? '0 : w_tick ? r_digit_idx + IW'(1) : r_digit_idx;
  assign w_blink_wrap = r_blink_cnt == BW'(BLINK_FRAMES - 1);
  assign w_nibble     = r_active[{r_digit_idx, 2'b00} +: 4];
  assign w_onehot     = NUM_DIGITS'(1) << r_digit_idx;

  // w_lz[k]: every nibble from k upward is zero
  always_comb begin
    w_lz = '0;
    for (int k = 0; k < NUM_DIGITS; k++) w_lz[k] = (r_active >> (4 * k)) == '0;
  end

  assign w_blank = (i_blank_lz && r_digit_idx != '0 && w_lz[r_digit_idx]) ||
                   (i_blink_mask[r_digit_idx] && r_blink_phase);

  ssd_hex_decode u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_div_cnt      <= '0;
      r_digit_idx    <= '0;
      r_shadow       <= '0;
      r_active       <= '0;
      r_load_pending <= 1'b0;
      r_blink_cnt    <= '0;
      r_blink_phase  <= 1'b0;
      r_frame_done   <= 1'b0;
      r_an           <= {NUM_DIGITS{AN_ACTIVE_LOW}};
      r_seg          <= {7{SEG_ACTIVE_LOW}};
      r_dp           <= SEG_ACTIVE_LOW;
    end else begin
      r_div_cnt      <= w_div_nxt;
      r_digit_idx    <= w_idx_nxt;
      r_frame_done   <= w_div_nxt == DW'(CLK_DIV - 1) && w_idx_nxt == IW'(NUM_DIGITS - 1);
      if (w_wrap && r_load_pending) r_active <= r_shadow;
      if (i_data_we) r_shadow <= i_data_in;
      r_load_pending <= i_data_we || (r_load_pending && !w_wrap);
      if (w_wrap) r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + BW'(1);
      if (w_wrap && w_blink_wrap) r_blink_phase <= !r_blink_phase;
      r_an           <= (i_enable ? w_onehot : '0) ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
      r_seg          <= (w_blank ? SEG_BLANK : w_glyph) ^ {7{SEG_ACTIVE_LOW}};
      r_dp           <= (i_dp_mask[r_digit_idx] && !w_blank) ^ SEG_ACTIVE_LOW;
    end
  end

  assign o_an           = r_an;
  assign o_seg          = r_seg;
  assign o_dp           = r_dp;
  assign o_frame_done   = r_frame_done;
  assign o_load_pending = r_load_pending;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: directed frames pushed to a scoreboard, checked slot by slot by a monitor
module tb_ssd_scan_ctrl;
  localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010, G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100, G5 = 7'b0100100, GB = 7'b1100000, GE = 7'b0110000;
  localparam logic [6:0] GF = 7'b0111000, BL = 7'b1111111;

  typedef struct packed {logic [3:0] an; logic [6:0] seg; logic dp;} slot_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data_in = '0;
  logic        data_we = 1'b0, enable = 1'b1, blank_lz = 1'b0;
  logic [3:0]  dp_mask = '0, blink_mask = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp, frame_done, load_pending;

  slot_t exp_q[$];
  int    n_vec = 0, n_err = 0;

  ssd_scan_ctrl #(
    .NUM_DIGITS(4), .CLK_DIV(4), .BLINK_FRAMES(2), .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_data_in(data_in), .i_data_we(data_we),
    .i_enable(enable), .i_blank_lz(blank_lz), .i_dp_mask(dp_mask), .i_blink_mask(blink_mask),
    .o_an(an), .o_seg(seg), .o_dp(dp), .o_frame_done(frame_done), .o_load_pending(load_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [6:0] s0, s1, s2, s3, input logic [3:0] dp_on);
    logic [6:0] s [4];
    slot_t e;
    s = '{s0, s1, s2, s3};
    for (int k = 0; k < 4; k++) begin
      e.an  = ~(4'b0001 << k);
      e.seg = s[k];
      e.dp  = ~dp_on[k];
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_fd();
    logic seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = frame_done;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL frame_done_timeout: got no pulse expected one within 40 cycles");
    end
  endtask

  task automatic write(input logic [15:0] v);
    data_in = v;
    data_we = 1'b1;
    @(negedge clk);
    data_we = 1'b0;
    check("pending_after_write", load_pending, 1'b1);
  endtask

  // Slot k of the frame that starts after a frame_done pulse is first visible 2+4k cycles later
  initial begin
    slot_t e, a;
    forever begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        for (int k = 0; k < 4; k++) begin
          repeat (k == 0 ? 2 : 4) @(negedge clk);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = '{an, seg, dp};
            n_vec++;
            if (a !== e) begin
              n_err++;
              $display("FAIL slot%0d: an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                       k, a.an, a.seg, a.dp, e.an, e.seg, e.dp);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] ea;
    repeat (3) @(negedge clk);
    check("reset_an", an, 4'hF);
    check("reset_seg", seg, 7'h7F);
    check("reset_dp", dp, 1'b1);
    check("reset_fd", frame_done, 1'b0);
    check("reset_pending", load_pending, 1'b0);
    reset = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      ea = ~(4'b0001 << (j / 4));
      check("scan_an", an, ea);
      check("scan_seg", seg, G0);
      check("scan_fd", frame_done, j == 14);
    end
    repeat (6) @(negedge clk);
    write(16'h1234);
    wait_fd();
    push_frame(G4, G3, G2, G1, 4'b0000);
    @(negedge clk);
    check("pending_cleared", load_pending, 1'b0);
    repeat (5) @(negedge clk);
    write(16'h0050);
    wait_fd();
    push_frame(G0, G5, G0, G0, 4'b0000);
    write(16'hBEEF);
    wait_fd();
    push_frame(GF, GE, GE, GB, 4'b0000);
    @(negedge clk);
    check("pending_after_collision_frame", load_pending, 1'b0);
    repeat (5) @(negedge clk);
    write(16'h0050);
    wait_fd();
    blank_lz = 1'b1;
    push_frame(G0, G5, BL, BL, 4'b0000);
    repeat (6) @(negedge clk);
    write(16'h0000);
    wait_fd();
    push_frame(G0, BL, BL, BL, 4'b0000);
    wait_fd();
    blank_lz = 1'b0;
    blink_mask = 4'b0001;
    dp_mask = 4'b0010;
    push_frame(BL, G0, G0, G0, 4'b0010);
    wait_fd();
    push_frame(G0, G0, G0, G0, 4'b0010);
    wait_fd();
    push_frame(G0, G0, G0, G0, 4'b0010);
    wait_fd();
    push_frame(BL, G0, G0, G0, 4'b0010);
    wait_fd();
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("disable_an", an, 4'hF);
    wait_fd();
    check("disabled_an_at_frame", an, 4'hF);
    enable = 1'b1;
    push_frame(G0, G0, G0, G0, 4'b0010);
    wait_fd();
    write(16'h1234);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_an", an, 4'hF);
    check("midreset_seg", seg, 7'h7F);
    check("midreset_pending", load_pending, 1'b0);
    reset = 1'b1;
    wait_fd();
    push_frame(G0, G0, G0, G0, 4'b0010);
    repeat (20) @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
